mem_bus_arbiter: RTL and testbench

Two-master to one-slave memory bus arbiter sitting between the core's bus masters and the single memory/peripheral slave. Master 1 is instruction fetch and master 2 is data access. The block serialises their requests and handles multi-cycle slave wait states. It returns read data and per-master completion pulses, and drives the global pipeline stall while any request is outstanding.

---
 rtl/mem_bus_arbiter_pkg.sv | 29 ++
 rtl/mem_bus_arbiter_arb_pick.sv | 41 ++++
 rtl/mem_bus_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
//   Shared constants for the two-master memory bus arbiter:
//   - FSM state encoding (ARB_IDLE, ARB_BUSY)
//   - bus owner encoding (OWN_M1 = fetch, OWN_M2 = data)
//   - default address/data widths and timeout
//   Optional build macro used by the arbiter files: MEM_ARB_RR_EN
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    // FSM state encoding
    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    // Owner encoding (also used for the last-owner bit in round-robin builds)
    localparam logic [0:0] OWN_M1 = 1'b0;
    localparam logic [0:0] OWN_M2 = 1'b1;

    // Default widths
    localparam int ARB_ADDR_W_DEF  = 64;
    localparam int ARB_DATA_W_DEF  = 64;
    localparam int ARB_TIMEOUT_DEF = 16;

    // Width of a counter that must hold 0 .. timeout-1
    function automatic int arb_cnt_w(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
//   Combinational winner select between the two bus masters.
//   Default build: fixed priority, master 2 wins a tie.
//   MEM_ARB_RR_EN defined: on a tie the master that was NOT served last wins.
//
// Ports:
//   req_1_i        in   effective request of master 1 (fetch)
//   req_2_i        in   effective request of master 2 (data)
//   last_owner_i   in   owner of the previous grant (MEM_ARB_RR_EN only)
//   grant_valid_o  out  at least one request is present
//   grant_owner_o  out  winning master (OWN_M1 / OWN_M2), don't-care if !valid
// -----------------------------------------------------------------------------
module arb_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic       req_1_i,
    input  logic       req_2_i,
`ifdef MEM_ARB_RR_EN
    input  logic [0:0] last_owner_i,
`endif
    output logic       grant_valid_o,
    output logic [0:0] grant_owner_o
);

    assign grant_valid_o = req_1_i | req_2_i;

    always_comb begin
        grant_owner_o = OWN_M2;
        if (req_1_i && !req_2_i) begin
            grant_owner_o = OWN_M1;
        end
`ifdef MEM_ARB_RR_EN
        // Tie: master 2 was served last, so master 1 takes this one.
        else if (req_1_i && req_2_i && (last_owner_i == OWN_M2)) begin
            grant_owner_o = OWN_M1;
        end
`endif
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Two-master (1 = fetch, 2 = data) to one-slave memory bus arbiter.
//   IDLE: pick a winner, register its address/write/wdata onto S_*, go BUSY.
//   BUSY: S_HSEL high; finish on S_HREADY (capture S_HRDATA) or abort after
//         TIMEOUT BUSY cycles without S_HREADY (HRDATA = 0, bus_err pulse).
//   Arbitration: fixed priority (master 2 wins) by default; round-robin when
//   the MEM_ARB_RR_EN macro is defined.
//
// Handshake: a master raises HTRANS_x with its address/data and holds them
//   until the one-cycle done_x pulse; done_x marks the transfer complete and
//   HRDATA valid. Dropping HTRANS_x early does not cancel a granted transfer.
//
// Ports:
//   CLK, RESET                 clock (rising edge), async active-low reset
//   HTRANS_x/HADDR_x/HWRITE_x/HWDATA_x   master x request
//   HRDATA                     read data of the last completed transfer
//   done_1, done_2, bus_err    completion / timeout-abort pulses
//   stall                      any request pending and not completing
//   S_HSEL/S_HADDR/S_HWRITE/S_HWDATA     registered slave request
//   S_HRDATA, S_HREADY         slave response
//   dbg_state_o                current FSM state (ARB_IDLE / ARB_BUSY)
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ARB_ADDR_W_DEF,
    parameter int DATA_W  = ARB_DATA_W_DEF,
    parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              HTRANS_1,
    input  logic [ADDR_W-1:0] HADDR_1,
    input  logic              HWRITE_1,
    input  logic [DATA_W-1:0] HWDATA_1,
    input  logic              HTRANS_2,
    input  logic [ADDR_W-1:0] HADDR_2,
    input  logic              HWRITE_2,
    input  logic [DATA_W-1:0] HWDATA_2,
    output logic [DATA_W-1:0] HRDATA,
    output logic              done_1,
    output logic              done_2,
    output logic              bus_err,
    output logic              stall,
    output logic              S_HSEL,
    output logic [ADDR_W-1:0] S_HADDR,
    output logic              S_HWRITE,
    output logic [DATA_W-1:0] S_HWDATA,
    input  logic [DATA_W-1:0] S_HRDATA,
    input  logic              S_HREADY,
    output logic [0:0]        dbg_state_o
);

    localparam int               CNT_W   = arb_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [0:0]        state_q,    state_d;
    logic [0:0]        owner_q,    owner_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [DATA_W-1:0] hrdata_q,   hrdata_d;
    logic              done_1_q,   done_1_d;
    logic              done_2_q,   done_2_d;
    logic              bus_err_q,  bus_err_d;
    logic [ADDR_W-1:0] s_haddr_q,  s_haddr_d;
    logic              s_hwrite_q, s_hwrite_d;
    logic [DATA_W-1:0] s_hwdata_q, s_hwdata_d;

    logic              req_1, req_2;
    logic              grant_valid;
    logic [0:0]        grant_owner;

    // A master still holds HTRANS during the cycle its done pulse is out;
    // masking it here keeps that finished request from being granted again.
    assign req_1 = HTRANS_1 & ~done_1_q;
    assign req_2 = HTRANS_2 & ~done_2_q;

`ifdef MEM_ARB_RR_EN
    logic [0:0] last_q, last_d;

    always_comb begin
        last_d = last_q;
        if ((state_q == ARB_IDLE) && grant_valid) begin
            last_d = grant_owner;
        end
    end

    // Resets to "master 1 served last" so master 2 wins the first tie.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last_q <= OWN_M1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    arb_pick u_arb_pick (
        .req_1_i       (req_1),
        .req_2_i       (req_2),
`ifdef MEM_ARB_RR_EN
        .last_owner_i  (last_q),
`endif
        .grant_valid_o (grant_valid),
        .grant_owner_o (grant_owner)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        hrdata_d   = hrdata_q;
        done_1_d   = 1'b0;
        done_2_d   = 1'b0;
        bus_err_d  = 1'b0;
        s_haddr_d  = s_haddr_q;
        s_hwrite_d = s_hwrite_q;
        s_hwdata_d = s_hwdata_q;

        case (state_q)
            ARB_IDLE: begin
                // S_HREADY is deliberately not looked at here.
                if (grant_valid) begin
                    owner_d = grant_owner;
                    cnt_d   = '0;
                    state_d = ARB_BUSY;
                    if (grant_owner == OWN_M2) begin
                        s_haddr_d  = HADDR_2;
                        s_hwrite_d = HWRITE_2;
                        s_hwdata_d = HWDATA_2;
                    end else begin
                        s_haddr_d  = HADDR_1;
                        s_hwrite_d = HWRITE_1;
                        s_hwdata_d = HWDATA_1;
                    end
                end
            end
            ARB_BUSY: begin
                // S_HREADY takes precedence over a timeout in the same cycle.
                if (S_HREADY) begin
                    hrdata_d = S_HRDATA;
                    done_1_d = (owner_q == OWN_M1);
                    done_2_d = (owner_q == OWN_M2);
                    state_d  = ARB_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    hrdata_d  = '0;
                    done_1_d  = (owner_q == OWN_M1);
                    done_2_d  = (owner_q == OWN_M2);
                    bus_err_d = 1'b1;
                    state_d   = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_M1;
            cnt_q      <= '0;
            hrdata_q   <= '0;
            done_1_q   <= 1'b0;
            done_2_q   <= 1'b0;
            bus_err_q  <= 1'b0;
            s_haddr_q  <= '0;
            s_hwrite_q <= 1'b0;
            s_hwdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            hrdata_q   <= hrdata_d;
            done_1_q   <= done_1_d;
            done_2_q   <= done_2_d;
            bus_err_q  <= bus_err_d;
            s_haddr_q  <= s_haddr_d;
            s_hwrite_q <= s_hwrite_d;
            s_hwdata_q <= s_hwdata_d;
        end
    end

    assign HRDATA      = hrdata_q;
    assign done_1      = done_1_q;
    assign done_2      = done_2_q;
    assign bus_err     = bus_err_q;
    assign S_HSEL      = (state_q == ARB_BUSY);
    assign S_HADDR     = s_haddr_q;
    assign S_HWRITE    = s_hwrite_q;
    assign S_HWDATA    = s_hwdata_q;
    assign dbg_state_o = state_q;
    assign stall       = (HTRANS_1 & ~done_1_q) | (HTRANS_2 & ~done_2_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Directed bench for mem_bus_arbiter (ADDR_W = DATA_W = 64, TIMEOUT = 16).
//   Single transfers come from a vector table; ties and reset-in-BUSY are
//   hand-written sequences. Expected tie order follows MEM_ARB_RR_EN.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        HTRANS_1 = 1'b0;
    logic [63:0] HADDR_1 = '0;
    logic        HWRITE_1 = 1'b0;
    logic [63:0] HWDATA_1 = '0;
    logic        HTRANS_2 = 1'b0;
    logic [63:0] HADDR_2 = '0;
    logic        HWRITE_2 = 1'b0;
    logic [63:0] HWDATA_2 = '0;
    logic [63:0] HRDATA;
    logic        done_1, done_2, bus_err, stall;
    logic        S_HSEL;
    logic [63:0] S_HADDR;
    logic        S_HWRITE;
    logic [63:0] S_HWDATA;
    logic [63:0] S_HRDATA = '0;
    logic        S_HREADY = 1'b0;
    logic [0:0]  dbg_state;

    mem_bus_arbiter #(
        .ADDR_W  (64),
        .DATA_W  (64),
        .TIMEOUT (16)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .HTRANS_1    (HTRANS_1),
        .HADDR_1     (HADDR_1),
        .HWRITE_1    (HWRITE_1),
        .HWDATA_1    (HWDATA_1),
        .HTRANS_2    (HTRANS_2),
        .HADDR_2     (HADDR_2),
        .HWRITE_2    (HWRITE_2),
        .HWDATA_2    (HWDATA_2),
        .HRDATA      (HRDATA),
        .done_1      (done_1),
        .done_2      (done_2),
        .bus_err     (bus_err),
        .stall       (stall),
        .S_HSEL      (S_HSEL),
        .S_HADDR     (S_HADDR),
        .S_HWRITE    (S_HWRITE),
        .S_HWDATA    (S_HWDATA),
        .S_HRDATA    (S_HRDATA),
        .S_HREADY    (S_HREADY),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_hrdata(input string name);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard queue empty", name);
        end else begin
            e = exp_q.pop_front();
            check(name, HRDATA, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int m, input logic on, input logic wr,
                           input logic [63:0] addr, input logic [63:0] wdata);
        if (m == 1) begin
            HTRANS_1 = on; HWRITE_1 = wr; HADDR_1 = addr; HWDATA_1 = wdata;
        end else begin
            HTRANS_2 = on; HWRITE_2 = wr; HADDR_2 = addr; HWDATA_2 = wdata;
        end
    endtask

    function automatic logic done_of(input int m);
        return (m == 1) ? done_1 : done_2;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        int          m;
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          waits;      // BUSY cycles with S_HREADY low; -1 = never ready
        logic        drop;       // master drops HTRANS after the grant
        logic [63:0] exp_rd;
        logic        exp_err;
        int          exp_lat;    // edges from request to done pulse
        int          exp_stall;  // cycles with stall high
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input int i);
        vec_t  v;
        int    lat, busy, stall_n;
        logic  stable_ok, got_done;
        string tag;
        v = vecs[i];
        tag = $sformatf("vec%0d", i);
        exp_q.push_back(v.exp_rd);
        S_HRDATA = v.rdata;
        S_HREADY = 1'b0;
        set_req(v.m, 1'b1, v.wr, v.addr, v.wdata);
        lat = 0; busy = 0; stall_n = 0; stable_ok = 1'b1; got_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (stall) stall_n++;
            tick();
            lat++;
            if (done_1 || done_2) begin
                got_done = 1'b1;
                break;
            end
            if (!S_HSEL || S_HADDR !== v.addr || S_HWRITE !== v.wr || S_HWDATA !== v.wdata)
                stable_ok = 1'b0;
            if (v.drop && busy == 0) set_req(v.m, 1'b0, v.wr, v.addr, v.wdata);
            S_HREADY = (v.waits >= 0) && (busy == v.waits);
            busy++;
        end
        check({tag, " done seen"}, {63'd0, got_done}, 64'd1);
        check({tag, " S_* stable"}, {63'd0, stable_ok}, 64'd1);
        check({tag, " done owner"}, {63'd0, done_of(v.m)}, 64'd1);
        check({tag, " done other"}, {63'd0, done_of(3 - v.m)}, 64'd0);
        check({tag, " bus_err"}, {63'd0, bus_err}, {63'd0, v.exp_err});
        check_hrdata({tag, " HRDATA"});
        check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
        check({tag, " stall cycles"}, 64'(stall_n), 64'(v.exp_stall));
        check({tag, " stall at done"}, {63'd0, stall}, 64'd0);
        set_req(v.m, 1'b0, 1'b0, v.addr, v.wdata);
        S_HREADY = 1'b0;
        tick();
        check({tag, " done cleared"}, {62'd0, done_1, done_2}, 64'd0);
        check({tag, " back to idle"}, {62'd0, S_HSEL, dbg_state}, 64'd0);
    endtask

    // Both masters request together; 'first' is the master expected to win.
    task automatic tie(input int first, input string tag);
        int second;
        second = 3 - first;
        set_req(1, 1'b1, 1'b0, 64'h2000, 64'h1111);
        set_req(2, 1'b1, 1'b1, 64'h8000, 64'hDEADBEEF);
        S_HREADY = 1'b1;
        S_HRDATA = 64'h77;
        exp_q.push_back(64'h77);
        exp_q.push_back(64'h77);
        tick();
        check({tag, " first addr"}, S_HADDR, (first == 2) ? 64'h8000 : 64'h2000);
        check({tag, " first write"}, {63'd0, S_HWRITE}, (first == 2) ? 64'd1 : 64'd0);
        check({tag, " first wdata"}, S_HWDATA, (first == 2) ? 64'hDEADBEEF : 64'h1111);
        tick();
        check({tag, " first done"}, {62'd0, done_1, done_2}, (first == 2) ? 64'd1 : 64'd2);
        check_hrdata({tag, " first HRDATA"});
        set_req(first, 1'b0, 1'b0, 64'h0, 64'h0);
        tick();
        check({tag, " second sel"}, {63'd0, S_HSEL}, 64'd1);
        check({tag, " second addr"}, S_HADDR, (second == 2) ? 64'h8000 : 64'h2000);
        check({tag, " no done yet"}, {62'd0, done_1, done_2}, 64'd0);
        tick();
        check({tag, " second done"}, {62'd0, done_1, done_2}, (second == 2) ? 64'd1 : 64'd2);
        check_hrdata({tag, " second HRDATA"});
        set_req(second, 1'b0, 1'b0, 64'h0, 64'h0);
        S_HREADY = 1'b0;
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        //              m  wr    addr                   wdata                  rdata                  waits drop  exp_rd                 err  lat stall
        vecs[0] = '{1, 1'b0, 64'h1000,              64'h0,                 64'h13,                0,  1'b0, 64'h13,                1'b0, 2,  2};
        vecs[1] = '{2, 1'b1, 64'h8000_0010,         64'hDEADBEEF,          64'h55,                0,  1'b0, 64'h55,                1'b0, 2,  2};
        vecs[2] = '{1, 1'b0, 64'h3000,              64'hA5,                64'hCAFE,              3,  1'b0, 64'hCAFE,              1'b0, 5,  5};
        vecs[3] = '{2, 1'b0, 64'h4000,              64'h0,                 64'h1234,              -1, 1'b0, 64'h0,                 1'b1, 17, 17};
        vecs[4] = '{1, 1'b0, 64'h5000,              64'h0,                 64'hABCD,              15, 1'b0, 64'hABCD,              1'b0, 17, 17};
        vecs[5] = '{1, 1'b1, 64'h6000,              64'h0123456789ABCDEF,  64'h5A5A,              14, 1'b0, 64'h5A5A,              1'b0, 16, 16};
        vecs[6] = '{2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,               64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3, 1};

        // reset
        RESET = 1'b0;
        repeat (3) tick();
        check("reset HRDATA", HRDATA, 64'h0);
        check("reset done/err", {61'd0, done_1, done_2, bus_err}, 64'd0);
        check("reset S_HSEL/state", {62'd0, S_HSEL, dbg_state}, 64'd0);
        check("reset S_HADDR", S_HADDR, 64'h0);
        check("reset S_HWRITE", {63'd0, S_HWRITE}, 64'd0);
        check("reset S_HWDATA", S_HWDATA, 64'h0);
        check("reset stall", {63'd0, stall}, 64'd0);
        RESET = 1'b1;
        tick();
        check("idle no request", {63'd0, S_HSEL}, 64'd0);

        // simultaneous requests right after reset: master 2 first in both builds
        tie(2, "tieA");

        // single transfers
        for (int i = 0; i < 7; i++) run_vec(i);

        // last served was master 2: round-robin now favours master 1
`ifdef MEM_ARB_RR_EN
        tie(1, "tieB");
`else
        tie(2, "tieB");
`endif

        // reset while BUSY, then restart of the still-pending fetch
        set_req(1, 1'b1, 1'b0, 64'h7000, 64'h0);
        S_HREADY = 1'b0;
        tick();
        check("rst busy sel", {63'd0, S_HSEL}, 64'd1);
        #3 RESET = 1'b0;
        #1;
        check("rst async sel/state", {62'd0, S_HSEL, dbg_state}, 64'd0);
        check("rst async S_HADDR", S_HADDR, 64'h0);
        check("rst async HRDATA", HRDATA, 64'h0);
        check("rst async done/err", {61'd0, done_1, done_2, bus_err}, 64'd0);
        @(negedge CLK);
        RESET = 1'b1;
        tick();
        check("rst restart sel", {63'd0, S_HSEL}, 64'd1);
        check("rst restart addr", S_HADDR, 64'h7000);
        S_HREADY = 1'b1;
        S_HRDATA = 64'h99;
        exp_q.push_back(64'h99);
        tick();
        check("rst restart done", {62'd0, done_1, done_2}, 64'd2);
        check_hrdata("rst restart HRDATA");
        set_req(1, 1'b0, 1'b0, 64'h0, 64'h0);
        S_HREADY = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
